// File: rtl/e_mdu_seq.sv
// E-stage multiply/divide sequencer: owns HI/LO and models the fixed MDU latency.
// Results are computed at issue and held in staging registers until the busy period ends.
module e_mdu_seq #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    input  logic        D_MD,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Operands widened to 66 bits so one signed multiplier covers mult and multu.
    function automatic logic [63:0] mul_res(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = is_signed ? {{34{a[31]}}, a} : {34'b0, a};
        eb = is_signed ? {{34{b[31]}}, b} : {34'b0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    // Returns {remainder, quotient}; 33-bit operands make 0x80000000 / -1 yield 0x80000000 rem 0.
    function automatic logic [63:0] div_res(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [32:0] q;
        logic signed [32:0] r;
        ea = {is_signed & a[31], a};
        eb = {is_signed & b[31], b};
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else begin
            q = ea / eb;
            r = ea % eb;
        end
        return {r[31:0], q[31:0]};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stg_hi_q, stg_hi_d;
    logic [31:0] stg_lo_q, stg_lo_d;
    logic        stg_wr_q, stg_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_md_op;
    logic        is_mul_op;
    logic        accept;
    logic [63:0] res;

    assign is_md_op  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                       (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign is_mul_op = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign accept    = Start & ~Req;
    assign res       = is_mul_op ? mul_res(MDUOp == OP_MULT, A, B)
                                 : div_res(MDUOp == OP_DIV, A, B);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            stg_hi_q <= '0;
            stg_lo_q <= '0;
            stg_wr_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stg_hi_q <= stg_hi_d;
            stg_lo_q <= stg_lo_d;
            stg_wr_q <= stg_wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stg_hi_d = stg_hi_q;
        stg_lo_d = stg_lo_q;
        stg_wr_d = stg_wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_md_op) begin
                    state_d  = S_RUN;
                    cnt_d    = is_mul_op ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    stg_hi_d = res[63:32];
                    stg_lo_d = res[31:0];
                    // A divide by zero still occupies the unit but leaves HI/LO untouched.
                    stg_wr_d = is_mul_op || (B != 32'd0);
                end else if (accept && MDUOp == OP_MTHI) begin
                    hi_d = A;
                end else if (accept && MDUOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (stg_wr_q) begin
                        hi_d = stg_hi_q;
                        lo_d = stg_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy  = (state_q == S_RUN);
    assign Stall = D_MD & (Busy | (accept & is_md_op));
    assign Done  = done_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: doc/e_mdu_seq.md
Name: e_mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer in the E stage, alongside the single-cycle ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E, models the fixed MDU latency, and owns the HI/LO registers.
- Generates the D-stage stall for any MDU-class instruction while an operation is pending.
- Squashes a start when the exception/interrupt request Req is raised in the same cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- Start  input  1  E-stage instruction is an MDU op; valid for one cycle
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand
- B  input  32  rt operand
- Req  input  1  exception/interrupt flush of E; suppresses Start this cycle
- D_MD  input  1  D-stage instruction is MDU-class (incl. mfhi/mflo)
- Busy  output  1  operation in progress
- Stall  output  1  D_MD & (Busy | (Start & op is 1..4 & ~Req))
- Done  output  1  one-cycle pulse after HI/LO commit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, Busy=0, Done=0, HI=0, LO=0, result staging regs 0.
- States: IDLE, RUN.
- IDLE, accepted Start (Start=1, ~Req, op 1..4):
  - compute result combinationally from A and B; latch it into staging regs at the edge.
  - load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - Busy=1 from the next cycle.
- IDLE, op 5/6 with Start=1 and ~Req: HI<=A (mthi) or LO<=A (mtlo) at the edge; no Busy, no Done.
- RUN:
  - counter decrements each edge.
  - at the edge where counter goes 1->0: HI/LO <= staging, state IDLE, Busy=0.
  - Done=1 for the following cycle.
  - Busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- Start while Busy: ignored (Stall must have prevented it); state, counter and staging are unchanged.
- Req during RUN: no effect. The running op is older than the flushed instruction and completes.
- Req=1 with Start=1: the op is discarded entirely. No Busy, no HI/LO write. Stall is not raised by that Start.
- Arithmetic:
  - mult: signed 64-bit product, {HI,LO}.
  - multu: unsigned 64-bit product, {HI,LO}.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): full busy period runs; HI/LO unchanged at commit.
- mfhi/mflo read HI/LO combinationally. The HI/LO value updated at a commit edge is visible in the next cycle.
- Reset asserted mid-RUN: immediate return to reset values; any pending result is lost.

Test Plan:
- Reset released, Start mult A=7, B=-3 (0xFFFFFFFD) -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulses once.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=5, B=0 with HI=0x11, LO=0x22 (set via mthi/mtlo) -> Busy 10 cycles; HI=0x11, LO=0x22 retained.
- Start div with Req=1 -> Busy stays 0, HI/LO unchanged, Stall=0 even with D_MD=1.
- Start mult, then D_MD=1 each cycle and a second Start mid-run -> Stall high for all 5 busy cycles; second Start ignored; one commit only.
